// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter with one-entry holding register, optional parity, 1 or 2 stop bits
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   baud_tick  one-clk pulse per bit period
//   tx_data    byte to transmit
//   tx_valid   tx_data is valid
//   tx_ready   holding register empty; byte taken when tx_valid && tx_ready
//   tx         registered serial line, idle high
//   tx_busy    high whenever the FSM is not idle
//   tx_done    one-clk pulse when the final stop bit of a frame completes

module uart_tx #(
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       baud_tick,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic USE_PARITY = (PARITY_EN != 0);
    localparam logic PAR_INIT   = (PARITY_ODD != 0);
    // stop_cnt value during the final stop bit
    localparam logic LAST_STOP  = (STOP_BITS == 2);

    state_t     state;
    logic [7:0] hold_data;
    logic       hold_full;
    logic [7:0] shift;
    logic [2:0] bit_cnt;
    logic       stop_cnt;
    logic       par_bit;

    assign tx_ready = !hold_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            hold_data <= 8'h00;
            hold_full <= 1'b0;
            shift     <= 8'h00;
            bit_cnt   <= 3'd0;
            stop_cnt  <= 1'b0;
            par_bit   <= 1'b0;
            tx        <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= 1'b0;

            // Accept only into an empty register; a load below only happens
            // when the register is full, so the two never collide.
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (baud_tick) begin
                case (state)
                    IDLE: begin
                        if (hold_full) begin
                            shift     <= hold_data;
                            par_bit   <= (^hold_data) ^ PAR_INIT;
                            hold_full <= 1'b0;
                            state     <= START;
                            tx        <= 1'b0;
                            tx_busy   <= 1'b1;
                        end
                    end
                    START: begin
                        state   <= DATA;
                        bit_cnt <= 3'd0;
                        tx      <= shift[0];
                    end
                    DATA: begin
                        if (bit_cnt == 3'd7) begin
                            stop_cnt <= 1'b0;
                            if (USE_PARITY) begin
                                state <= PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            // shift[1] is the next bit before the shift lands
                            bit_cnt <= bit_cnt + 3'd1;
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                        end
                    end
                    PARITY: begin
                        state    <= STOP;
                        stop_cnt <= 1'b0;
                        tx       <= 1'b1;
                    end
                    STOP: begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_done <= 1'b1;
                            if (hold_full) begin
                                // chain straight into the next frame, no idle gap
                                shift     <= hold_data;
                                par_bit   <= (^hold_data) ^ PAR_INIT;
                                hold_full <= 1'b0;
                                state     <= START;
                                tx        <= 1'b0;
                            end else begin
                                state   <= IDLE;
                                tx_busy <= 1'b0;
                            end
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
